// File: rtl/aes_192_decrypt_if.sv
// Handshake bundle for the AES-192 decryptor: key load, ciphertext in,
// plaintext out and a busy status flag.
interface aes_192_decrypt_if;
    logic [191:0] key;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] ct;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output key, key_valid, ct, in_valid, out_ready,
        input  key_ready, in_ready, pt, out_valid, busy
    );

    modport slave (
        input  key, key_valid, ct, in_valid, out_ready,
        output key_ready, in_ready, pt, out_valid, busy
    );
endinterface

// File: rtl/aes_192_decrypt.sv
// Iterative AES-192 decryptor: one-time key expansion into a local word file,
// then one inverse round per clock with valid/ready handshakes on every port.
package aes_192_decrypt_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a);
        return gf_mul(x127, x127);
    endfunction

    // Byte k of a state lives at bits [127-8k -: 8]; k = 4*column + row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// Forward S-box: field inverse followed by the affine map.
module aes_sbox
    import aes_192_decrypt_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b_s;

    // Inverse then affine transform.
    always_comb begin
        b_s = gf_inv(a);
        y   = b_s ^ {b_s[6:0], b_s[7]} ^ {b_s[5:0], b_s[7:6]}
                  ^ {b_s[4:0], b_s[7:5]} ^ {b_s[3:0], b_s[7:4]} ^ 8'h63;
    end
endmodule

// Inverse S-box: inverse affine map followed by the field inverse.
module aes_inv_sbox
    import aes_192_decrypt_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b_s;

    // Undo the affine map, then invert in GF(2^8).
    always_comb begin
        b_s = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        y   = gf_inv(b_s);
    end
endmodule

module aes_192_decrypt
    import aes_192_decrypt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    aes_192_decrypt_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_READY = 3'd2,
        ST_DEC   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic         key_ready_s;
    logic         in_ready_s;
    logic         busy_s;
    logic         key_fire_s;
    logic         ct_fire_s;

    logic [31:0]  w_r    [0:51];
    logic [31:0]  prev_r [0:5];
    logic [31:0]  new_s  [0:5];
    logic [5:0]   widx_s [0:5];
    logic [3:0]   kiter_r;
    logic [7:0]   rcon_r;
    logic [31:0]  rot_s;
    logic [31:0]  subw_s;
    logic [5:0]   base_s;

    logic [127:0] dstate_r;
    logic [127:0] pt_r;
    logic [3:0]   round_r;
    logic         out_valid_r;
    logic [127:0] shifted_s;
    logic [127:0] sub_s;
    logic [127:0] rk_sel_s;
    logic [127:0] add_s;
    logic [127:0] mix_s;
    logic [127:0] rk12_s;
    logic [5:0]   rk_idx_s;

    assign bus.key_ready = key_ready_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.busy      = busy_s;
    assign bus.out_valid = out_valid_r;
    assign bus.pt        = pt_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Next-state and handshake decode; a key offer in READY masks in_ready.
    always_comb begin
        state_s     = state_r;
        key_ready_s = 1'b0;
        in_ready_s  = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                key_ready_s = 1'b1;
                if (bus.key_valid) state_s = ST_KEXP;
                else               state_s = ST_IDLE;
            end
            ST_KEXP: begin
                busy_s = 1'b1;
                if (kiter_r == 4'd8) state_s = ST_READY;
                else                 state_s = ST_KEXP;
            end
            ST_READY: begin
                key_ready_s = 1'b1;
                in_ready_s  = !bus.key_valid;
                if (bus.key_valid)     state_s = ST_KEXP;
                else if (bus.in_valid) state_s = ST_DEC;
                else                   state_s = ST_READY;
            end
            ST_DEC: begin
                busy_s = 1'b1;
                if (round_r == 4'd0) state_s = ST_DONE;
                else                 state_s = ST_DEC;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                if (bus.out_ready) state_s = ST_READY;
                else               state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign key_fire_s = key_ready_s & bus.key_valid;
    assign ct_fire_s  = in_ready_s & bus.in_valid;

    // Key schedule datapath: one 6-word iteration from the previous six words.
    always_comb begin
        rot_s    = {prev_r[5][23:0], prev_r[5][31:24]};
        new_s[0] = prev_r[0] ^ subw_s ^ {rcon_r, 24'h000000};
        for (int j = 1; j < 6; j++) begin
            new_s[j] = prev_r[j] ^ new_s[j-1];
        end
        base_s = 6'({kiter_r, 1'b0}) + {kiter_r, 2'b00};
        for (int j = 0; j < 6; j++) begin
            widx_s[j] = base_s + 6'(j);
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ksbox
            aes_sbox u_sbox (.a(rot_s[31-8*g -: 8]), .y(subw_s[31-8*g -: 8]));
        end
        for (g = 0; g < 16; g++) begin : g_isbox
            aes_inv_sbox u_isbox (.a(shifted_s[127-8*g -: 8]), .y(sub_s[127-8*g -: 8]));
        end
    endgenerate

    // Key load and expansion into the round-key word file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 52; i++) w_r[i] <= 32'h0;
            for (int j = 0; j < 6; j++)  prev_r[j] <= 32'h0;
            kiter_r <= 4'd0;
            rcon_r  <= 8'h00;
        end else if (key_fire_s) begin
            for (int j = 0; j < 6; j++) begin
                w_r[j]    <= bus.key[191-32*j -: 32];
                prev_r[j] <= bus.key[191-32*j -: 32];
            end
            kiter_r <= 4'd1;
            rcon_r  <= 8'h01;
        end else if (state_r == ST_KEXP) begin
            for (int j = 0; j < 6; j++) begin
                prev_r[j] <= new_s[j];
                if (widx_s[j] < 6'd52) w_r[widx_s[j]] <= new_s[j];
            end
            kiter_r <= kiter_r + 4'd1;
            rcon_r  <= xtime(rcon_r);
        end
    end

    // Inverse round datapath; the round counter selects rk[round].
    always_comb begin
        rk_idx_s  = {round_r, 2'b00};
        rk_sel_s  = {w_r[rk_idx_s], w_r[rk_idx_s + 6'd1], w_r[rk_idx_s + 6'd2], w_r[rk_idx_s + 6'd3]};
        rk12_s    = {w_r[48], w_r[49], w_r[50], w_r[51]};
        shifted_s = inv_shift_rows(dstate_r);
        add_s     = sub_s ^ rk_sel_s;
        mix_s     = inv_mix_columns(add_s);
    end

    // Block state, round counter and registered plaintext/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_r    <= 128'h0;
            round_r     <= 4'd0;
            pt_r        <= 128'h0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_READY: begin
                    if (ct_fire_s) begin
                        dstate_r <= bus.ct ^ rk12_s;
                        round_r  <= 4'd11;
                    end
                end
                ST_DEC: begin
                    if (round_r == 4'd0) begin
                        pt_r        <= add_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        dstate_r <= mix_s;
                        round_r  <= round_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_192_decrypt.sv
// Self-checking bench for aes_192_decrypt: FIPS-197 vector, back-pressure,
// key priority, ignored inputs, reset abort and random encrypt/decrypt round trips.
module tb_aes_192_decrypt;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_192_decrypt_if bus();
    aes_192_decrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] PT_C2  = 128'h00112233445566778899aabbccddeeff;

    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_abort = 0;
    int n_in_hs = 0;
    int n_out_hs = 0;
    logic [127:0] exp_q [$];
    logic [7:0] sb [256];

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready)   n_in_hs  <= n_in_hs + 1;
        if (rst_n && bus.out_valid && bus.out_ready) n_out_hs <= n_out_hs + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference encryptor ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] encrypt(input logic [191:0] k, input logic [127:0] p);
        logic [31:0]  w [52];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, o;
        for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
        for (int r = 0; r < 13; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++) u[4*c+q] = s[4*((c+q)%4)+q];
                for (int c = 0; c < 4; c++) begin
                    a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                    if (r < 12) begin
                        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end else begin
                        s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                    end
                end
            end
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [191:0] k, output int lat, output bit to);
        int n;
        to = 1'b0;
        bus.key = k;
        bus.key_valid = 1'b1;
        #1;
        n = 0;
        while (bus.key_ready !== 1'b1 && n < 64) begin tick(); n++; end
        if (n >= 64) to = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        lat = 0;
        #1;
        while (bus.in_ready !== 1'b1 && lat < 64) begin tick(); lat++; end
        if (lat >= 64) to = 1'b1;
    endtask

    task automatic send_ct(input logic [127:0] c, output bit to);
        int n;
        to = 1'b0;
        bus.ct = c;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin tick(); n++; end
        if (n >= 64) to = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit to);
        lat = 0;
        to = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin tick(); lat++; end
        if (lat >= 64) to = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.key = '0; bus.key_valid = 1'b0; bus.ct = '0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready: got %b want 1", bus.key_ready); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.pt !== 128'h0) begin n_err++; $display("FAIL reset_pt: got %h want 0", bus.pt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_fips_c2();
        int lat; bit to; logic [127:0] exp;
        load_key(KEY_C2, lat, to);
        n_cmp++; if (to || lat != 8) begin n_err++; $display("FAIL c2_key_latency: got %0d timeout=%0b want 8", lat, to); end
        exp_q.push_back(PT_C2); n_push++;
        send_ct(CT_C2, to);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL c2_busy: got %b want 1", bus.busy); end
        wait_out(lat, to);
        n_cmp++; if (to || lat != 12) begin n_err++; $display("FAIL c2_dec_latency: got %0d timeout=%0b want 12", lat, to); end
        exp = exp_q.pop_front();
        n_cmp++; if (bus.pt !== exp) begin n_err++; $display("FAIL c2_pt: got %h want %h", bus.pt, exp); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL c2_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_back_pressure();
        int lat; bit to; logic [127:0] exp; int hs0; bit bad;
        bus.out_ready = 1'b0;
        exp_q.push_back(PT_C2); n_push++;
        send_ct(CT_C2, to);
        wait_out(lat, to);
        n_cmp++; if (to || lat != 12) begin n_err++; $display("FAIL bp_latency: got %0d want 12", lat); end
        exp = exp_q.pop_front();
        hs0 = n_out_hs;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.pt !== exp || bus.in_ready !== 1'b0 || bus.key_ready !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL bp_hold: out_valid=%b pt=%h in_ready=%b key_ready=%b want 1/%h/0/0",
                 bus.out_valid, bus.pt, bus.in_ready, bus.key_ready, exp); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || n_out_hs != hs0 + 1) begin
            n_err++; $display("FAIL bp_handshake: out_valid=%b handshakes=%0d want 0/%0d", bus.out_valid, n_out_hs - hs0, 1); end
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL bp_ready: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_key_priority();
        logic [191:0] k2; logic [127:0] p2, c2, exp; int lat, hs0; bit to;
        k2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        p2 = 128'h6bc1bee22e409f96e93d7e117393172a;
        c2 = encrypt(k2, p2);
        hs0 = n_in_hs;
        bus.key = k2; bus.key_valid = 1'b1; bus.ct = c2; bus.in_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.key_ready !== 1'b1) begin
            n_err++; $display("FAIL prio_ready: in_ready=%b key_ready=%b want 0/1", bus.in_ready, bus.key_ready); end
        tick();
        bus.key_valid = 1'b0;
        n_cmp++; if (n_in_hs != hs0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL prio_ct_taken: in handshakes=%0d busy=%b want 0/1", n_in_hs - hs0, bus.busy); end
        lat = 0;
        #1;
        while (bus.in_ready !== 1'b1 && lat < 64) begin tick(); lat++; end
        n_cmp++; if (lat != 8) begin n_err++; $display("FAIL prio_key_latency: got %0d want 8", lat); end
        exp_q.push_back(p2); n_push++;
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat, to);
        n_cmp++; if (to || lat != 12) begin n_err++; $display("FAIL prio_dec_latency: got %0d want 12", lat); end
        exp = exp_q.pop_front();
        n_cmp++; if (bus.pt !== exp) begin n_err++; $display("FAIL prio_pt: got %h want %h", bus.pt, exp); end
        tick();
    endtask

    task automatic test_ignored();
        int lat; bit to, bad; logic [127:0] exp; int hs0;
        bus.key = KEY_C2; bus.key_valid = 1'b1;
        #1;
        tick();
        bus.key_valid = 1'b0;
        bad = 1'b0; lat = 0;
        for (int i = 0; i < 3; i++) begin
            bus.key = ~KEY_C2; bus.key_valid = 1'b1; bus.in_valid = 1'b1; bus.ct = CT_C2;
            #1;
            if (bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0) bad = 1'b1;
            tick(); lat++;
        end
        bus.key_valid = 1'b0; bus.in_valid = 1'b0;
        #1;
        while (bus.in_ready !== 1'b1 && lat < 64) begin tick(); lat++; end
        n_cmp++; if (bad || lat != 8) begin n_err++; $display("FAIL ign_kexp: lat=%0d ready_seen=%0b want 8/0", lat, bad); end
        exp_q.push_back(PT_C2); n_push++;
        send_ct(CT_C2, to);
        hs0 = n_in_hs;
        bad = 1'b0; lat = 0;
        for (int i = 0; i < 4; i++) begin
            bus.key = ~KEY_C2; bus.key_valid = 1'b1; bus.in_valid = 1'b1; bus.ct = ~CT_C2;
            #1;
            if (bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
            tick(); lat++;
        end
        bus.key_valid = 1'b0; bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin tick(); lat++; end
        n_cmp++; if (bad || lat != 12 || n_in_hs != hs0) begin
            n_err++; $display("FAIL ign_dec: lat=%0d ready_seen=%0b extra_hs=%0d want 12/0/0", lat, bad, n_in_hs - hs0); end
        exp = exp_q.pop_front();
        n_cmp++; if (bus.pt !== exp) begin n_err++; $display("FAIL ign_pt: got %h want %h", bus.pt, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; bit to, bad; logic [127:0] exp;
        send_ct(CT_C2, to);
        n_abort++;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.pt !== 128'h0 || bus.key_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: out_valid=%b pt=%h key_ready=%b in_ready=%b want 0/0/1/0",
                              bus.out_valid, bus.pt, bus.key_ready, bus.in_ready); end
        tick(); tick();
        rst_n = 1'b1;
        bus.ct = CT_C2; bus.in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bad) begin n_err++; $display("FAIL rst_no_key: ct accepted or output flagged without a key"); end
        load_key(KEY_C2, lat, to);
        exp_q.push_back(PT_C2); n_push++;
        send_ct(CT_C2, to);
        wait_out(lat, to);
        exp = exp_q.pop_front();
        n_cmp++; if (to || bus.pt !== exp) begin n_err++; $display("FAIL rst_recover_pt: got %h want %h", bus.pt, exp); end
        tick();
    endtask

    task automatic test_round_trip();
        logic [191:0] k; logic [127:0] p, c, exp; int lat; bit to;
        k = KEY_C2;
        for (int i = 0; i < 1000; i++) begin
            if (i % 4 == 0) begin
                k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                load_key(k, lat, to);
            end
            p = {$urandom, $urandom, $urandom, $urandom};
            c = encrypt(k, p);
            repeat ($urandom_range(0, 2)) tick();
            bus.out_ready = 1'b0;
            exp_q.push_back(p); n_push++;
            send_ct(c, to);
            wait_out(lat, to);
            repeat ($urandom_range(0, 3)) tick();
            if (exp_q.size() == 0) exp = 128'hx;
            else exp = exp_q.pop_front();
            n_cmp++; if (to || lat < 12 || bus.pt !== exp || bus.out_valid !== 1'b1) begin
                n_err++; $display("FAIL roundtrip[%0d]: pt=%h want %h lat=%0d", i, bus.pt, exp, lat); end
            bus.out_ready = 1'b1;
            tick();
        end
        n_cmp++; if (exp_q.size() != 0 || n_out_hs != n_push || n_in_hs != n_push + n_abort) begin
            n_err++; $display("FAIL handshake_count: in=%0d out=%0d pushed=%0d aborted=%0d left=%0d",
                              n_in_hs, n_out_hs, n_push, n_abort, exp_q.size()); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c2();
        test_back_pressure();
        test_key_priority();
        test_ignored();
        test_reset_mid();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
